// File: rtl/seg_scan_pkg.sv
// Shared constants for the multiplexed 7-segment scan path.
// The driver and the decoder both use these patterns, so they cannot drift apart.
package seg_scan_pkg;

    // Active-high segment patterns, bit0=a ... bit6=g
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] BCD_BLANK   = 4'hA;
    localparam logic [3:0] BCD_INVALID = 4'hF;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } frame_state_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational 7-segment pattern to BCD decoder.
// A dark digit decodes to BLANK; anything unrecognised decodes to INVALID with the flag set.
module seg7_to_bcd
    import seg_scan_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] code_o,
    output logic       invalid_o
);

    always_comb begin
        code_o    = BCD_INVALID;
        invalid_o = 1'b1;
        case (pattern_i)
            SEG_0:     begin code_o = 4'd0;      invalid_o = 1'b0; end
            SEG_1:     begin code_o = 4'd1;      invalid_o = 1'b0; end
            SEG_2:     begin code_o = 4'd2;      invalid_o = 1'b0; end
            SEG_3:     begin code_o = 4'd3;      invalid_o = 1'b0; end
            SEG_4:     begin code_o = 4'd4;      invalid_o = 1'b0; end
            SEG_5:     begin code_o = 4'd5;      invalid_o = 1'b0; end
            SEG_6:     begin code_o = 4'd6;      invalid_o = 1'b0; end
            SEG_7:     begin code_o = 4'd7;      invalid_o = 1'b0; end
            SEG_8:     begin code_o = 4'd8;      invalid_o = 1'b0; end
            SEG_9:     begin code_o = 4'd9;      invalid_o = 1'b0; end
            SEG_BLANK: begin code_o = BCD_BLANK; invalid_o = 1'b0; end
            default:   begin code_o = BCD_INVALID; invalid_o = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Samples a multiplexed 7-segment bus, filters switching glitches, decodes each stable
// digit to BCD and assembles complete in-order scans into a frame word.
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS    = 3,
    parameter int STABLE_CYCLES = 4,
    parameter int SEL_W         = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              seg,
    input  logic [SEL_W-1:0]        sel,
    output logic [4*NUM_DIGITS-1:0] digit_bcd,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [4*NUM_DIGITS-1:0] frame_bcd,
    output logic                    frame_valid,
    output logic                    pat_err,
    output logic                    seq_err
);

    localparam int                CNT_W     = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STABLE_CYCLES);
    localparam logic [SEL_W:0]    SEL_LIMIT = (SEL_W + 1)'(NUM_DIGITS);
    localparam logic [SEL_W-1:0]  LAST_SEL  = SEL_W'(NUM_DIGITS - 1);

    logic [6:0]              s_seg_q;
    logic [SEL_W-1:0]        s_sel_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    cap_q, cap_d;
    logic                    same_sample;

    frame_state_e            state_q, state_d;
    logic [SEL_W-1:0]        expect_q, expect_d;
    logic [4*NUM_DIGITS-1:0] buf_q, buf_d;
    logic [4*NUM_DIGITS-1:0] digit_q, digit_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic [4*NUM_DIGITS-1:0] frame_q, frame_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    pat_err_q, pat_err_d;
    logic                    seq_err_q, seq_err_d;

    logic [3:0]              dec_code;
    logic                    dec_invalid;
    logic                    sel_in_range;
    logic                    dp_unused;

    assign dp_unused = seg[7];

    // The sample about to be registered is compared with the one already held, so the
    // counter reaches STABLE_CYCLES on the edge that takes the last required sample.
    always_comb begin
        same_sample = (seg[6:0] == s_seg_q) && (sel == s_sel_q);
        cnt_d       = CNT_W'(1);
        cap_d       = 1'b0;
        if (same_sample) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            cap_d = (cnt_q == CNT_MAX - CNT_W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_seg_q <= '0;
            s_sel_q <= '0;
            cnt_q   <= '0;
            cap_q   <= 1'b0;
        end else begin
            s_seg_q <= seg[6:0];
            s_sel_q <= sel;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
        end
    end

    seg7_to_bcd u_dec (
        .pattern_i (s_seg_q),
        .code_o    (dec_code),
        .invalid_o (dec_invalid)
    );

    assign sel_in_range = ({1'b0, s_sel_q} < SEL_LIMIT);

    // Capture handling. The buffer slot is written on every in-range capture; a frame only
    // commits after slots 0..N-1 were written in order, so stale slots never leak out.
    always_comb begin
        state_d       = state_q;
        expect_d      = expect_q;
        buf_d         = buf_q;
        digit_d       = digit_q;
        valid_d       = valid_q;
        frame_d       = frame_q;
        frame_valid_d = 1'b0;
        pat_err_d     = 1'b0;
        seq_err_d     = 1'b0;

        if (cap_q) begin
            pat_err_d = dec_invalid;
            if (!sel_in_range) begin
                seq_err_d = 1'b1;
                state_d   = ST_IDLE;
            end else begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (s_sel_q == SEL_W'(i)) begin
                        digit_d[4*i +: 4] = dec_code;
                        valid_d[i]        = 1'b1;
                        buf_d[4*i +: 4]   = dec_code;
                    end
                end

                case (state_q)
                    ST_IDLE: begin
                        if (s_sel_q == '0) begin
                            expect_d = SEL_W'(1);
                            state_d  = ST_COLLECT;
                        end
                    end
                    ST_COLLECT: begin
                        if (s_sel_q == expect_q) begin
                            if (expect_q == LAST_SEL) begin
                                frame_d       = buf_d;
                                frame_valid_d = 1'b1;
                                state_d       = ST_IDLE;
                            end else begin
                                expect_d = expect_q + SEL_W'(1);
                            end
                        end else begin
                            seq_err_d = 1'b1;
                            if (s_sel_q == '0) begin
                                expect_d = SEL_W'(1);
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            expect_q      <= '0;
            buf_q         <= '0;
            digit_q       <= '0;
            valid_q       <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            pat_err_q     <= 1'b0;
            seq_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            expect_q      <= expect_d;
            buf_q         <= buf_d;
            digit_q       <= digit_d;
            valid_q       <= valid_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            pat_err_q     <= pat_err_d;
            seq_err_q     <= seq_err_d;
        end
    end

    assign digit_bcd   = digit_q;
    assign digit_valid = valid_q;
    assign frame_bcd   = frame_q;
    assign frame_valid = frame_valid_q;
    assign pat_err     = pat_err_q;
    assign seq_err     = seq_err_q;

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side companion to the team's multiplexed 7-segment scan driver. It samples the shared segment bus and digit-select lines, filters switching glitches, and decodes each stable segment pattern back to a BCD value. It assembles complete in-order scans into a frame word. It sits on the board-observation and self-check path, either on-chip or in the bench harness, and lets displayed digits (e.g. an ID such as 1-0-9) be checked numerically.

## Interface
Parameters:
- NUM_DIGITS, 3: digits per scan; range 2..8.
- STABLE_CYCLES, 4: consecutive identical samples required before a capture; minimum 2.
- SEL_W, 3: width of the digit-select bus; must satisfy 2^SEL_W >= NUM_DIGITS.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- seg  in  8  segment pattern, active-high; bit0=a … bit6=g, bit7=dp (ignored).
- sel  in  SEL_W  binary index of the digit currently driven.
- digit_bcd  out  4*NUM_DIGITS  last captured code per digit; digit i occupies [4i+3:4i].
- digit_valid  out  NUM_DIGITS  bit i is set once digit i has been captured since reset.
- frame_bcd  out  4*NUM_DIGITS  codes of the last complete in-order scan, same packing.
- frame_valid  out  1  one-cycle pulse when frame_bcd updates.
- pat_err  out  1  one-cycle pulse when a capture decodes to no known pattern.
- seq_err  out  1  one-cycle pulse on an out-of-order or out-of-range select.

## Operation
- Input stage: seg[6:0] and sel are registered once into s_seg and s_sel.
- Stability counter: if {s_sel,s_seg} equals the previous sample, the counter increments, saturating at STABLE_CYCLES. Otherwise it loads 1.
- Capture event: fires for exactly one cycle when the counter transitions to STABLE_CYCLES. It fires once per dwell, however long the dwell lasts.
- Decode of seg[6:0]:
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9.
  - 0x00→0xA (blank). A blank is a valid code and raises no error.
  - Any other pattern→0xF and pulses pat_err.
- On a capture with s_sel < NUM_DIGITS: write the code to digit_bcd[s_sel] and set digit_valid[s_sel].
- On a capture with s_sel >= NUM_DIGITS: no digit write, pulse seq_err, and the FSM goes to IDLE.
- Frame FSM, with states IDLE and COLLECT and an index register `expect`:
  - IDLE: a capture with sel=0 stores into the frame buffer, sets expect=1, and moves to COLLECT. Captures with any other sel are ignored and raise no error.
  - COLLECT, capture with sel==expect: store the code.
    - If expect==NUM_DIGITS-1: copy the buffer plus this code into frame_bcd, pulse frame_valid, and go to IDLE.
    - Otherwise: increment expect.
  - COLLECT, capture with sel!=expect: pulse seq_err.
    - If sel==0: restart the frame (store, expect=1, stay in COLLECT).
    - Otherwise: go to IDLE.
- A frame containing a 0xF digit still commits. pat_err and frame_valid may pulse in the same cycle.
- Reset value of every output and register is 0, and the FSM resets to IDLE. Reset mid-frame discards the partial buffer.

## Timing
- A new {seg,sel} value held steady and first presented before edge t0 is registered at t0.
- The counter reaches STABLE_CYCLES after edge t0+STABLE_CYCLES-1.
- digit_bcd, digit_valid, pat_err, seq_err, frame_bcd and frame_valid update at edge t0+STABLE_CYCLES.
- Latency from input change to output update is therefore STABLE_CYCLES+1 edges.
- Any value held for fewer than STABLE_CYCLES samples produces no capture and no error.
- All outputs are registered. No combinational path runs from an input to an output.
- The minimum driver dwell for reliable decode is STABLE_CYCLES+1 cycles per digit.

## Structure
- Shared package seg_scan_pkg holds:
  - the ten segment-pattern constants;
  - the BLANK (4'hA) and INVALID (4'hF) codes;
  - the FSM state enum.

  The driver side reuses the same pattern constants.
- One combinational sub-module, seg7_to_bcd: 7-bit pattern in, 4-bit code and invalid flag out.
- Counter width is clog2(STABLE_CYCLES+1).

## Test plan
- Drive a scan of sel 0,1,2 with seg 0x06, 0x3F, 0x6F, 8 cycles each, repeated. Required: frame_bcd=12'h901, one frame_valid pulse per 24 cycles, and no errors.
- Insert a 2-cycle glitch (sel=1, seg=0x7F) inside a sel=0 dwell. Required: no capture, digit_bcd unchanged, no errors.
- Drive pattern 0x49 on sel=1 within a full scan. Required: digit_bcd[7:4]=0xF, pat_err pulses once, and the frame commits as 12'h9F1.
- Drive sel 0 then sel 2, skipping 1. Required: seq_err pulses, no frame_valid, and a subsequent correct scan commits.
- Drive sel=5 with seg 0x3F. Required: seq_err pulses, digit_bcd and digit_valid unchanged.
- Assert rst after digits 0 and 1 have been captured. Required: all outputs 0 immediately. The next full scan commits a frame only after a fresh sel=0 capture.
